// File: rtl/c_xbar_conn_ctrl_pkg.sv
// Shared constants and helpers for the crossbar connection controller.
// Provides the reset-type encodings and the clogb width helper.
package c_xbar_conn_ctrl_pkg;

    localparam int RESET_TYPE_ASYNC = 0;
    localparam int RESET_TYPE_SYNC  = 1;

    function automatic int clogb(input int value);
        int r;
        r = 0;
        for (int k = 0; k < 31; k++) begin
            if ((1 << k) < value) begin
                r = k + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/c_xbar_conn_port.sv
// Per-input connection tracker: IDLE/CONN state, held destination,
// request row decode and transfer acknowledge.
module c_xbar_conn_port
    import c_xbar_conn_ctrl_pkg::*;
#(
    parameter int num_ports = 8,
    parameter int idx_w     = clogb(num_ports)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 active,
    input  logic                 valid,
    input  logic                 head,
    input  logic                 tail,
    input  logic [idx_w-1:0]     dest,
    input  logic [num_ports-1:0] out_ready,
    input  logic [num_ports-1:0] lock,
    input  logic [num_ports-1:0] gnt,
    output logic [num_ports-1:0] req,
    output logic [num_ports-1:0] sel,
    output logic                 ack,
    output logic                 conn,
    output logic [idx_w-1:0]     conn_dest
);

    typedef enum logic {IDLE, CONN} state_t;

    state_t               state;
    logic [num_ports-1:0] dec;
    logic [num_ports-1:0] cdec;
    logic                 take;

    // One-hot decodes; an out-of-range index simply matches no column.
    always_comb begin
        dec  = '0;
        cdec = '0;
        for (int j = 0; j < num_ports; j++) begin
            dec[j]  = (dest == idx_w'(j));
            cdec[j] = (conn_dest == idx_w'(j));
        end
    end

    always_comb begin
        req  = '0;
        sel  = '0;
        ack  = 1'b0;
        take = 1'b0;
        if (state == IDLE) begin
            if (valid && head) begin
                req = dec & out_ready & ~lock;
            end
            take = |(req & gnt);
            if (take) begin
                sel = req;
                ack = 1'b1;
            end
        end else if (valid && |(cdec & out_ready)) begin
            sel = cdec;
            ack = 1'b1;
        end
    end

    assign conn = (state == CONN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            conn_dest <= '0;
        end else if (active) begin
            unique case (state)
                IDLE: begin
                    if (take && !tail) begin
                        state     <= CONN;
                        conn_dest <= dest;
                    end
                end
                CONN: begin
                    if (ack && tail) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/c_xbar_conn_ctrl.sv
// Packet connection controller in front of an external switch allocator;
// holds granted input-to-output paths until the tail flit crosses.
module c_xbar_conn_ctrl
    import c_xbar_conn_ctrl_pkg::*;
#(
    parameter int num_ports = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  active,
    input  logic [num_ports-1:0]                  req_valid,
    input  logic [num_ports-1:0]                  req_head,
    input  logic [num_ports-1:0]                  req_tail,
    input  logic [num_ports*clogb(num_ports)-1:0] req_dest,
    input  logic [num_ports-1:0]                  out_ready,
    output logic [num_ports*num_ports-1:0]        alloc_req,
    input  logic [num_ports*num_ports-1:0]        alloc_gnt,
    output logic                                  alloc_update,
    output logic [num_ports*num_ports-1:0]        xbar_sel,
    output logic [num_ports-1:0]                  in_ack
);

    localparam int port_idx_width = clogb(num_ports);

    logic [num_ports-1:0]      conn;
    logic [port_idx_width-1:0] conn_dest [num_ports];
    logic [num_ports-1:0]      lock;

    // Locks come from registered state only, so a released output is
    // grantable the cycle after its tail, never the same cycle.
    always_comb begin
        lock = '0;
        for (int i = 0; i < num_ports; i++) begin
            for (int j = 0; j < num_ports; j++) begin
                if (conn[i] && conn_dest[i] == port_idx_width'(j)) begin
                    lock[j] = 1'b1;
                end
            end
        end
    end

    assign alloc_update = active & (|alloc_gnt);

    for (genvar i = 0; i < num_ports; i++) begin : g_port
        c_xbar_conn_port #(
            .num_ports (num_ports),
            .idx_w     (port_idx_width)
        ) u_port (
            .clk       (clk),
            .reset     (reset),
            .active    (active),
            .valid     (req_valid[i]),
            .head      (req_head[i]),
            .tail      (req_tail[i]),
            .dest      (req_dest[i*port_idx_width +: port_idx_width]),
            .out_ready (out_ready),
            .lock      (lock),
            .gnt       (alloc_gnt[i*num_ports +: num_ports] & ~lock),
            .req       (alloc_req[i*num_ports +: num_ports]),
            .sel       (xbar_sel[i*num_ports +: num_ports]),
            .ack       (in_ack[i]),
            .conn      (conn[i]),
            .conn_dest (conn_dest[i])
        );
    end

endmodule

// File: tb/tb_c_xbar_conn_ctrl.sv
// Directed bench for c_xbar_conn_ctrl: 4-port main instance plus a
// 5-port instance for out-of-range destinations.
module tb_c_xbar_conn_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        active;
    logic [3:0]  rv, rh, rt, ordy, ack;
    logic [7:0]  rd;
    logic [15:0] areq, gnt, sel;
    logic        upd;

    logic [4:0]  rv5, rh5, rt5, ordy5, ack5;
    logic [14:0] rd5;
    logic [24:0] areq5, gnt5, sel5;
    logic        upd5;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    c_xbar_conn_ctrl #(.num_ports(4)) dut (
        .clk(clk), .reset(reset), .active(active),
        .req_valid(rv), .req_head(rh), .req_tail(rt), .req_dest(rd),
        .out_ready(ordy), .alloc_req(areq), .alloc_gnt(gnt),
        .alloc_update(upd), .xbar_sel(sel), .in_ack(ack)
    );

    c_xbar_conn_ctrl #(.num_ports(5)) dut5 (
        .clk(clk), .reset(reset), .active(active),
        .req_valid(rv5), .req_head(rh5), .req_tail(rt5), .req_dest(rd5),
        .out_ready(ordy5), .alloc_req(areq5), .alloc_gnt(gnt5),
        .alloc_update(upd5), .xbar_sel(sel5), .in_ack(ack5)
    );

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rv = '0; rh = '0; rt = '0; rd = '0; gnt = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; active = 1'b1; ordy = 4'hF;
        idle_inputs();
        rv5 = '0; rh5 = '0; rt5 = '0; rd5 = '0; gnt5 = '0; ordy5 = 5'h1F;
        nxt(); nxt();
        @(negedge clk);
        checks++; if (areq !== 16'h0) begin errors++; $display("FAIL reset_req got=%h exp=0000", areq); end
        checks++; if (sel !== 16'h0) begin errors++; $display("FAIL reset_sel got=%h exp=0000", sel); end
        checks++; if (ack !== 4'h0) begin errors++; $display("FAIL reset_ack got=%b exp=0000", ack); end
        checks++; if (upd !== 1'b0) begin errors++; $display("FAIL reset_upd got=%b exp=0", upd); end
        nxt();
        reset = 1'b0;
        nxt();
    endtask

    task automatic test_single_flit();
        idle_inputs();
        rv = 4'b0001; rh = 4'b0001; rt = 4'b0001; rd[1:0] = 2'd2;
        gnt = 16'h0004;
        @(negedge clk);
        checks++; if (areq !== 16'h0004) begin errors++; $display("FAIL single_req got=%h exp=0004", areq); end
        checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL single_ack got=%b exp=0001", ack); end
        checks++; if (sel !== 16'h0004) begin errors++; $display("FAIL single_sel got=%h exp=0004", sel); end
        checks++; if (upd !== 1'b1) begin errors++; $display("FAIL single_upd got=%b exp=1", upd); end
        nxt();
        idle_inputs();
        rv = 4'b1000; rh = 4'b1000; rd[7:6] = 2'd2;
        @(negedge clk);
        checks++; if (areq !== 16'h4000) begin errors++; $display("FAIL single_unlocked got=%h exp=4000", areq); end
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL single_nogrant_ack got=%b exp=0000", ack); end
        nxt();
    endtask

    task automatic test_packet_contention_backpressure();
        idle_inputs();
        rv = 4'b0010; rh = 4'b0010; rd[3:2] = 2'd3; gnt = 16'h0080;
        @(negedge clk);
        checks++; if (ack !== 4'b0010 || sel !== 16'h0080) begin errors++; $display("FAIL pkt_head ack=%b sel=%h exp ack=0010 sel=0080", ack, sel); end
        nxt();
        gnt = '0; rv = 4'b0110; rh = 4'b0100; rd[5:4] = 2'd3;
        @(negedge clk);
        checks++; if (areq !== 16'h0) begin errors++; $display("FAIL pkt_body_req got=%h exp=0000", areq); end
        checks++; if (ack !== 4'b0010 || sel !== 16'h0080) begin errors++; $display("FAIL pkt_body ack=%b sel=%h exp ack=0010 sel=0080", ack, sel); end
        checks++; if (upd !== 1'b0) begin errors++; $display("FAIL pkt_body_upd got=%b exp=0", upd); end
        nxt();
        rt = 4'b0010;
        @(negedge clk);
        checks++; if (areq !== 16'h0) begin errors++; $display("FAIL pkt_tail_req got=%h exp=0000", areq); end
        checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL pkt_tail_ack got=%b exp=0010", ack); end
        nxt();
        rv = 4'b0100; rt = '0; gnt = 16'h0800;
        @(negedge clk);
        checks++; if (areq !== 16'h0800) begin errors++; $display("FAIL contend_req got=%h exp=0800", areq); end
        checks++; if (ack !== 4'b0100 || sel !== 16'h0800) begin errors++; $display("FAIL contend_grant ack=%b sel=%h exp ack=0100 sel=0800", ack, sel); end
        nxt();
        gnt = '0; rh = '0; ordy = 4'b0111;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++; if (ack !== 4'b0000 || sel !== 16'h0 || areq !== 16'h0) begin errors++; $display("FAIL bp_hold%0d ack=%b sel=%h req=%h exp all zero", k, ack, sel, areq); end
            nxt();
        end
        ordy = 4'hF; rv = 4'b0101; rh = 4'b0001; rd[1:0] = 2'd3;
        @(negedge clk);
        checks++; if (ack !== 4'b0100 || sel !== 16'h0800) begin errors++; $display("FAIL bp_resume ack=%b sel=%h exp ack=0100 sel=0800", ack, sel); end
        checks++; if (areq !== 16'h0) begin errors++; $display("FAIL bp_locked_req got=%h exp=0000", areq); end
        nxt();
        rt = 4'b0100;
        @(negedge clk);
        checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL bp_tail_ack got=%b exp=0100", ack); end
        nxt();
        rv = 4'b0001; rt = '0;
        @(negedge clk);
        checks++; if (areq !== 16'h0008) begin errors++; $display("FAIL bp_release_req got=%h exp=0008", areq); end
        nxt();
    endtask

    task automatic test_reset_mid_packet();
        idle_inputs();
        rv = 4'b1000; rh = 4'b1000; rd[7:6] = 2'd1; gnt = 16'h2000;
        @(negedge clk);
        checks++; if (ack !== 4'b1000 || sel !== 16'h2000) begin errors++; $display("FAIL mid_head ack=%b sel=%h exp ack=1000 sel=2000", ack, sel); end
        nxt();
        gnt = '0; rh = '0;
        @(negedge clk);
        checks++; if (ack !== 4'b1000 || sel !== 16'h2000) begin errors++; $display("FAIL mid_body ack=%b sel=%h exp ack=1000 sel=2000", ack, sel); end
        nxt();
        reset = 1'b1;
        @(negedge clk);
        checks++; if (ack !== 4'b0 || sel !== 16'h0 || areq !== 16'h0) begin errors++; $display("FAIL mid_reset ack=%b sel=%h req=%h exp all zero", ack, sel, areq); end
        nxt();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (ack !== 4'b0 || areq !== 16'h0) begin errors++; $display("FAIL mid_stall ack=%b req=%h exp all zero", ack, areq); end
        nxt();
        rh = 4'b1000; rt = 4'b1000; gnt = 16'h2000;
        @(negedge clk);
        checks++; if (areq !== 16'h2000 || ack !== 4'b1000) begin errors++; $display("FAIL mid_fresh req=%h ack=%b exp req=2000 ack=1000", areq, ack); end
        nxt();
    endtask

    task automatic test_active_hold();
        idle_inputs();
        active = 1'b0;
        rv = 4'b0001; rh = 4'b0001; rd[1:0] = 2'd1; gnt = 16'h0002;
        @(negedge clk);
        checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL inactive_ack got=%b exp=0001", ack); end
        checks++; if (upd !== 1'b0) begin errors++; $display("FAIL inactive_upd got=%b exp=0", upd); end
        nxt();
        active = 1'b1; gnt = '0;
        rv = 4'b0011; rh = 4'b0010; rd[3:2] = 2'd1;
        @(negedge clk);
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL headless_ack got=%b exp=0000", ack); end
        checks++; if (areq !== 16'h0020) begin errors++; $display("FAIL headless_req got=%h exp=0020", areq); end
        nxt();
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        rv = 4'b0011; rh = 4'b0011; rt = 4'b0011;
        rd[1:0] = 2'd0; rd[3:2] = 2'd1; gnt = 16'h0021;
        @(negedge clk);
        checks++; if (areq !== 16'h0021) begin errors++; $display("FAIL b2b_req got=%h exp=0021", areq); end
        checks++; if (ack !== 4'b0011 || sel !== 16'h0021) begin errors++; $display("FAIL b2b_grant ack=%b sel=%h exp ack=0011 sel=0021", ack, sel); end
        nxt();
        idle_inputs();
    endtask

    task automatic test_dest_range();
        rv5 = 5'b00001; rh5 = 5'b00001; rt5 = 5'b00001; rd5[2:0] = 3'd5;
        @(negedge clk);
        checks++; if (areq5 !== 25'h0 || ack5 !== 5'h0) begin errors++; $display("FAIL range_oob req=%h ack=%b exp zero", areq5, ack5); end
        nxt();
        rd5[2:0] = 3'd4;
        @(negedge clk);
        checks++; if (areq5 !== 25'h0000010) begin errors++; $display("FAIL range_edge req=%h exp=0000010", areq5); end
        nxt();
        rv5 = '0;
    endtask

    initial begin
        test_reset();
        test_single_flit();
        test_packet_contention_backpressure();
        test_reset_mid_packet();
        test_active_hold();
        test_back_to_back();
        test_dest_range();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/c_xbar_conn_ctrl.md
# c_xbar_conn_ctrl

Packet-level connection controller that sits between router input ports and the wavefront switch allocator. Converts per-input head/body/tail flit requests into an allocation request matrix, consumes the allocator's grant matrix, then holds each granted input→output connection until the tail flit crosses. Drives crossbar select and per-input accept signals, and pulses the allocator's priority update.

## Interface
- num_ports, 8: number of crossbar inputs and outputs.
- port_idx_width, clogb(num_ports): derived localparam, width of a destination index.
- reset_type, `RESET_TYPE_ASYNC: fixed to asynchronous.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- active  in  1  register enable; upstream holds it at 1 whenever any req_valid or connection is open.
- req_valid  in  num_ports  flit present at input i.
- req_head  in  num_ports  flit is a packet head.
- req_tail  in  num_ports  flit is a packet tail; head and tail both set means a single-flit packet.
- req_dest  in  num_ports*port_idx_width  destination output per input; valid only on head flits.
- out_ready  in  num_ports  output j can take a flit this cycle.
- alloc_req  out  num_ports*num_ports  row i, column j: input i requests output j.
- alloc_gnt  in  num_ports*num_ports  same-cycle grant matrix from allocator; at most one bit per row and column.
- alloc_update  out  1  allocator priority advance.
- xbar_sel  out  num_ports*num_ports  row i, column j: input i drives output j this cycle.
- in_ack  out  num_ports  flit at input i transferred this cycle.

## Operation
- Per-input state: IDLE or CONN. CONN stores a port_idx_width destination. Per-output lock bit = OR of all CONN inputs targeting that output, computed from registered state.
- IDLE input i raises alloc_req[i][d] only when all hold: req_valid, req_head, d=req_dest<num_ports, out_ready[d], output d unlocked. Out-of-range dest: no request, flit stalls.
- IDLE with valid but no head: protocol error; no request, no ack, state unchanged.
- A grant to IDLE input i implies transfer: in_ack[i]=1, xbar_sel[i][d]=1. If tail is clear, the next state is CONN(d). If tail is set, the input stays IDLE.
- CONN input i never requests. It transfers when req_valid and out_ready[dest]: in_ack and xbar_sel set. On a tail transfer the next state is IDLE and the lock clears. A CONN head flit is a protocol error; treat it as body.
- Backpressure in CONN (out_ready=0): no ack, connection held indefinitely.
- alloc_update = OR of alloc_gnt, gated by active. It is 1 in any cycle with at least one new grant.
- Grant bits in rows whose input is CONN, or in columns that are locked, are ignored. Such a grant is an allocator fault.

## Timing
- Request→grant→ack path is combinational within one cycle. Zero-cycle latency from head valid to in_ack when uncontended.
- State updates on the clk edge after transfer. An output released by a tail in cycle t is grantable to another input at t+1, not at t.
- A body flit can follow its head in cycle t+1 with no bubble.
- Reset: all inputs IDLE, all locks clear. alloc_req, xbar_sel, in_ack and alloc_update are 0 until req_valid is asserted.
- Reset mid-packet drops every connection. Remaining body flits then present as headless in IDLE and stall; upstream flushes them.
- active=0: registers hold their value. Combinational outputs still follow the inputs.

## Structure
- Constants live in the existing shared constants/functions includes: reset types and clogb. No new package types are needed.
- One sub-module, c_xbar_conn_port: per-input IDLE/CONN flop, dest register, request row decode and ack logic, instantiated num_ports times.
- Top level owns the lock OR-reduction, column masking and alloc_update reduction.
- The allocator is external. Connect it via alloc_req/alloc_gnt/alloc_update.

## Test plan
- num_ports=4, reset released. Input 0 presents head+tail, dest 2, out_ready=1111, allocator grants [0][2] → same cycle in_ack=0001b on bit 0, xbar_sel[0][2]=1, alloc_update=1; state stays IDLE.
- Input 1 sends a 3-flit packet to output 3 → cycle 0 grant. Cycles 1–2: alloc_req row 1 = 0, in_ack[1]=1 each cycle. Cycle 3: output 3 unlocked.
- While input 1 holds output 3, input 2 sends head dest 3 → alloc_req[2][3]=0 until the cycle after input 1's tail. It is granted that cycle.
- In CONN, out_ready[3]=0 for 5 cycles → in_ack[1]=0 and connection retained. When out_ready returns to 1, the transfer resumes without reallocation.
- Assert reset during an open 4-flit packet after flit 2 → all outputs 0. Flit 3 (no head) stalls with no request; a fresh head is then granted normally.
- Body flit at an IDLE input, and a head with dest 5 when num_ports=5 → neither requests nor acks.
